// File: rtl/pc_pkg.sv
// Shared width helpers, the default pc type and the next-pc source selector.
package pc_pkg;

    function automatic int pc_aw(input int rom_size);
        return $clog2(rom_size) + 1;
    endfunction

    function automatic int pc_dw(input int stack_depth);
        return $clog2(stack_depth + 1);
    endfunction

    localparam int DEF_ROM_SIZE = 512;
    localparam int DEF_AW       = pc_aw(DEF_ROM_SIZE);

    typedef logic [DEF_AW-1:0] pc_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_START,
        SEL_RET,
        SEL_REL,
        SEL_SKIP,
        SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; push when full and pop when empty leave it untouched.
module ret_stack
    import pc_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = 10,
    localparam int DW    = pc_dw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    // Storage rounded up to a power of two so the pointer indexes it cleanly.
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << IW;

    logic [AW-1:0] mem [SLOTS];
    logic [DW-1:0] ptr;

    assign full  = (ptr == DW'(DEPTH));
    assign empty = (ptr == '0);
    assign depth = ptr;
    assign dout  = empty ? '0 : mem[IW'(ptr - DW'(1))];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr <= '0;
        end else if (pop) begin
            if (!empty) begin
                ptr <= ptr - DW'(1);
            end
        end else if (push && !full) begin
            mem[IW'(ptr)] <= din;
            ptr           <= ptr + DW'(1);
        end
    end

endmodule

// File: rtl/prog_counter_rs.sv
// Fetch-stage program counter with return-address stack, stall, halt and
// sticky stack error flags.
module prog_counter_rs
    import pc_pkg::*;
#(
    parameter  int ROM_SIZE    = 512,
    parameter  int TGT_WIDTH   = 8,
    parameter  int STACK_DEPTH = 4,
    parameter  int SKIP        = 2,
    localparam int AW          = pc_aw(ROM_SIZE),
    localparam int DW          = pc_dw(STACK_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        start_addr,
    input  logic                 stall,
    input  logic                 branch,
    input  logic                 taken,
    input  logic [TGT_WIDTH-1:0] target,
    input  logic                 call,
    input  logic                 ret,
    input  logic                 halt,
    output logic [AW-1:0]        pc_out,
    output logic                 halted,
    output logic [DW-1:0]        stk_depth,
    output logic                 stk_ovf,
    output logic                 stk_unf
);

    logic [AW-1:0] pc_q;
    logic          halted_q;
    logic          ovf_q;
    logic          unf_q;

    pc_sel_e       sel;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_unf;
    logic          go_halt;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_rel;
    logic [AW-1:0] pc_skip;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .AW    (AW)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign pc_inc  = pc_q + AW'(1);
    assign pc_skip = pc_q + AW'(SKIP);
    assign pc_rel  = pc_q + {{(AW - TGT_WIDTH){target[TGT_WIDTH-1]}}, target};

    // Priority decode; ret beats call so a malformed call+ret behaves as ret.
    always_comb begin
        sel     = SEL_INC;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        go_halt = 1'b0;
        if (start) begin
            sel = SEL_START;
        end else if (halted_q || stall) begin
            sel = SEL_HOLD;
        end else if (halt) begin
            sel     = SEL_HOLD;
            go_halt = 1'b1;
        end else if (ret) begin
            if (stk_empty) begin
                sel     = SEL_INC;
                set_unf = 1'b1;
            end else begin
                sel = SEL_RET;
                pop = 1'b1;
            end
        end else if (call) begin
            sel = SEL_REL;
            if (stk_full) begin
                set_ovf = 1'b1;
            end else begin
                push = 1'b1;
            end
        end else if (taken) begin
            sel = SEL_REL;
        end else if (branch) begin
            sel = SEL_SKIP;
        end
    end

    always_comb begin
        pc_next = pc_q;
        case (sel)
            SEL_HOLD:  pc_next = pc_q;
            SEL_START: pc_next = start_addr;
            SEL_RET:   pc_next = stk_top;
            SEL_REL:   pc_next = pc_rel;
            SEL_SKIP:  pc_next = pc_skip;
            SEL_INC:   pc_next = pc_inc;
            default:   pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (start) begin
            pc_q     <= pc_next;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (go_halt) begin
                halted_q <= 1'b1;
            end
            if (set_ovf) begin
                ovf_q <= 1'b1;
            end
            if (set_unf) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign pc_out  = pc_q;
    assign halted  = halted_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule
